// File: rtl/mul_sched_if.sv
// Request/response, multiplier-side and control signals of the shared multiplier scheduler.
// The slave modport is the scheduler's view; master is the view of the pipes plus the multiplier.
interface mul_sched_if #(
  parameter int TAG_W = 5
);
  logic [1:0]       req_i;
  logic [1:0]       flush_i;
  logic [31:0]      a0_i;
  logic [31:0]      b0_i;
  logic             sgn0_i;
  logic [TAG_W-1:0] tag0_i;
  logic [31:0]      a1_i;
  logic [31:0]      b1_i;
  logic             sgn1_i;
  logic [TAG_W-1:0] tag1_i;
  logic [1:0]       gnt_o;
  logic             busy_o;
  logic [1:0]       resp_valid_o;
  logic [1:0]       resp_ready_i;
  logic [63:0]      resp_result_o;
  logic [TAG_W-1:0] resp_tag_o;
  logic [31:0]      mul_a_o;
  logic [31:0]      mul_b_o;
  logic             mul_signed_o;
  logic             mul_start_o;
  logic             mul_flush_o;
  logic [63:0]      mul_result_i;
  logic             mul_ready_i;

  modport slave (
    input  req_i, flush_i, a0_i, b0_i, sgn0_i, tag0_i, a1_i, b1_i, sgn1_i, tag1_i,
    input  resp_ready_i, mul_result_i, mul_ready_i,
    output gnt_o, busy_o, resp_valid_o, resp_result_o, resp_tag_o,
    output mul_a_o, mul_b_o, mul_signed_o, mul_start_o, mul_flush_o
  );

  modport master (
    output req_i, flush_i, a0_i, b0_i, sgn0_i, tag0_i, a1_i, b1_i, sgn1_i, tag1_i,
    output resp_ready_i, mul_result_i, mul_ready_i,
    input  gnt_o, busy_o, resp_valid_o, resp_result_o, resp_tag_o,
    input  mul_a_o, mul_b_o, mul_signed_o, mul_start_o, mul_flush_o
  );
endinterface

// File: rtl/mul_sched.sv
// Round-robin sharing of one 32x32 one-shot multiplier between two issue pipes.
// Define MUL_SCHED_BYPASS_EN to forward the product combinationally in the cycle mul_ready_i fires.
module mul_sched #(
  parameter int TAG_W = 5
) (
  input logic         clk,
  input logic         rst,
  mul_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_last_q, rr_last_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [63:0]      result_q, result_d;

  logic [1:0]       elig;
  logic             pick;
  logic             own_flush;
  logic [1:0]       gnt_c;
  logic [1:0]       valid_c;
  logic             flush_c;
  logic [63:0]      resp_result_c;

  assign elig      = bus.req_i & ~bus.flush_i;
  assign own_flush = bus.flush_i[owner_q];
  // Both eligible: the pipe that did not win last time goes first.
  assign pick      = (elig == 2'b11) ? ~rr_last_q : elig[1];

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_last_d     = rr_last_q;
    a_d           = a_q;
    b_d           = b_q;
    sgn_d         = sgn_q;
    tag_d         = tag_q;
    result_d      = result_q;
    gnt_c         = 2'b00;
    valid_c       = 2'b00;
    flush_c       = 1'b0;
    resp_result_c = result_q;

    case (state_q)
      IDLE: begin
        if (elig != 2'b00) begin
          gnt_c[pick] = 1'b1;
          owner_d     = pick;
          rr_last_d   = pick;
          a_d         = pick ? bus.a1_i   : bus.a0_i;
          b_d         = pick ? bus.b1_i   : bus.b0_i;
          sgn_d       = pick ? bus.sgn1_i : bus.sgn0_i;
          tag_d       = pick ? bus.tag1_i : bus.tag0_i;
          state_d     = START;
        end
      end
      START: begin
        if (own_flush) begin
          flush_c = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (own_flush) begin
          flush_c = 1'b1;
          state_d = IDLE;
        end else if (bus.mul_ready_i) begin
`ifdef MUL_SCHED_BYPASS_EN
          valid_c[owner_q] = 1'b1;
          resp_result_c    = bus.mul_result_i;
          if (bus.resp_ready_i[owner_q]) begin
            state_d = IDLE;
          end else begin
            result_d = bus.mul_result_i;
            state_d  = RESP;
          end
`else
          result_d = bus.mul_result_i;
          state_d  = RESP;
`endif
        end
      end
      RESP: begin
        // A flush in the same cycle as ready kills the handshake.
        if (own_flush) begin
          flush_c = 1'b1;
          state_d = IDLE;
        end else begin
          valid_c[owner_q] = 1'b1;
          if (bus.resp_ready_i[owner_q]) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      tag_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      tag_q     <= tag_d;
      result_q  <= result_d;
    end
  end

  // Handshake outputs are suppressed while rst is high so no grant or response leaks out.
  assign bus.gnt_o         = rst ? 2'b00 : gnt_c;
  assign bus.resp_valid_o  = rst ? 2'b00 : valid_c;
  assign bus.resp_result_o = resp_result_c;
  assign bus.resp_tag_o    = tag_q;
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.mul_a_o       = a_q;
  assign bus.mul_b_o       = b_q;
  assign bus.mul_signed_o  = sgn_q;
  assign bus.mul_start_o   = (state_q == START) && !own_flush && !rst;
  assign bus.mul_flush_o   = rst | flush_c;

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched: a stand-in multiplier with adjustable latency, plus a
// scoreboard whose monitor pops expected {pipe, product, tag} on every response handshake.
module tb_mul_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_sched_if #(.TAG_W(5)) bus ();
  mul_sched #(.TAG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct packed {
    logic        pipe;
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Multiplier stand-in: product is combinational on the operands, ready pulses lat cycles after start.
  logic [2:0] lat = 3'd1;
  logic [2:0] cnt = 3'd0;
  always @(posedge clk) begin
    if (rst || bus.mul_flush_o) cnt <= 3'd0;
    else if (bus.mul_start_o)   cnt <= lat;
    else if (cnt != 3'd0)       cnt <= cnt - 3'd1;
  end
  assign bus.mul_ready_i = (cnt == 3'd1);
  always_comb begin
    if (bus.mul_signed_o)
      bus.mul_result_i = {{32{bus.mul_a_o[31]}}, bus.mul_a_o} * {{32{bus.mul_b_o[31]}}, bus.mul_b_o};
    else
      bus.mul_result_i = {32'd0, bus.mul_a_o} * {32'd0, bus.mul_b_o};
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted response must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.resp_valid_o == 2'b11) begin
        n_cmp++;
        n_fail++;
        $display("FAIL resp_onehot: got %b expected one-hot", bus.resp_valid_o);
      end
      for (int k = 0; k < 2; k++) begin
        if (bus.resp_valid_o[k] && bus.resp_ready_i[k]) begin
          $display("resp pipe=%0d tag=%0d result=%h", k, bus.resp_tag_o, bus.resp_result_o);
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_resp: got response on pipe %0d expected none", k);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_pipe", 64'(k), 64'(e.pipe));
            chk("resp_result", bus.resp_result_o, e.res);
            chk("resp_tag", 64'(bus.resp_tag_o), 64'(e.tag));
          end
        end
      end
    end
  end

  task automatic cyc(string nm, logic [1:0] eg, logic es, logic [1:0] ev);
    @(negedge clk);
    chk({nm, "_gnt"}, 64'(bus.gnt_o), 64'(eg));
    chk({nm, "_start"}, 64'(bus.mul_start_o), 64'(es));
    chk({nm, "_valid"}, 64'(bus.resp_valid_o), 64'(ev));
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(string nm, int budget);
    int c = 0;
    while ((bus.busy_o || sb.size() != 0) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk({nm, "_done_in_budget"}, 64'(c < budget), 64'd1);
  endtask

  task automatic set_p0(logic [31:0] a, logic [31:0] b, logic s, logic [4:0] t);
    bus.a0_i = a; bus.b0_i = b; bus.sgn0_i = s; bus.tag0_i = t;
  endtask

  task automatic set_p1(logic [31:0] a, logic [31:0] b, logic s, logic [4:0] t);
    bus.a1_i = a; bus.b1_i = b; bus.sgn1_i = s; bus.tag1_i = t;
  endtask

  logic [1:0] order [3];
  int         ng;
  int         c;

  initial begin
    order = '{2'b01, 2'b10, 2'b01};
    bus.req_i = 2'b11; bus.flush_i = 2'b00; bus.resp_ready_i = 2'b11;
    set_p0(32'd0, 32'd0, 1'b0, 5'd0);
    set_p1(32'd0, 32'd0, 1'b0, 5'd0);

    // Reset behaviour
    @(negedge clk);
    chk("rst_gnt", 64'(bus.gnt_o), 64'd0);
    chk("rst_mul_flush", 64'(bus.mul_flush_o), 64'd1);
    bus.req_i = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_busy", 64'(bus.busy_o), 64'd0);
    chk("rel_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("rel_mul_flush", 64'(bus.mul_flush_o), 64'd0);
    chk("rel_mul_a", 64'(bus.mul_a_o), 64'd0);
    @(posedge clk); #1;

    // T1: pipe 0 signed 3 * -4
    set_p0(32'd3, 32'hFFFF_FFFC, 1'b1, 5'd7);
    bus.req_i = 2'b01;
    sb.push_back('{1'b0, 64'hFFFF_FFFF_FFFF_FFF4, 5'd7});
    cyc("t1_T0", 2'b01, 1'b0, 2'b00);
    bus.req_i = 2'b00;
    cyc("t1_T1", 2'b00, 1'b1, 2'b00);
`ifdef MUL_SCHED_BYPASS_EN
    cyc("t1_T2", 2'b00, 1'b0, 2'b01);
`else
    cyc("t1_T2", 2'b00, 1'b0, 2'b00);
    cyc("t1_T3", 2'b00, 1'b0, 2'b01);
`endif
    wait_idle("t1", 10);

    // T2: pipe 1 unsigned max * max
    set_p1(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd12);
    bus.req_i = 2'b10;
    sb.push_back('{1'b1, 64'hFFFF_FFFE_0000_0001, 5'd12});
    cyc("t2_T0", 2'b10, 1'b0, 2'b00);
    bus.req_i = 2'b00;
    wait_idle("t2", 10);

    // T3: both pipes request continuously
    set_p0(32'd5, 32'd7, 1'b0, 5'd1);
    set_p1(32'h0001_0000, 32'h0001_0000, 1'b0, 5'd2);
    bus.req_i = 2'b11;
    ng = 0;
    for (c = 0; c < 60 && ng < 3; c++) begin
      @(negedge clk);
      if (bus.busy_o) chk("t3_gnt_while_busy", 64'(bus.gnt_o), 64'd0);
      if (bus.gnt_o != 2'b00) begin
        chk("t3_order", 64'(bus.gnt_o), 64'(order[ng]));
        if (bus.gnt_o[1]) sb.push_back('{1'b1, 64'h0000_0001_0000_0000, 5'd2});
        else              sb.push_back('{1'b0, 64'h0000_0000_0000_0023, 5'd1});
        ng++;
      end
      @(posedge clk); #1;
      if (ng == 3) bus.req_i = 2'b00;
    end
    chk("t3_three_grants", 64'(ng), 64'd3);
    wait_idle("t3", 20);

    // T4: owner stalls in RESP while pipe 1 waits
    bus.resp_ready_i = 2'b10;
    set_p0(32'd2, 32'h8000_0000, 1'b1, 5'd3);
    set_p1(32'hFFFF_FFFF, 32'd2, 1'b1, 5'd4);
    bus.req_i = 2'b01;
    sb.push_back('{1'b0, 64'hFFFF_FFFF_0000_0000, 5'd3});
    cyc("t4_T0", 2'b01, 1'b0, 2'b00);
    bus.req_i = 2'b10;
    for (c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.resp_valid_o != 2'b00) break;
      chk("t4_pre_gnt", 64'(bus.gnt_o), 64'd0);
      @(posedge clk); #1;
    end
    chk("t4_valid_in_budget", 64'(c < 10), 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; @(negedge clk); end
      chk("t4_hold_valid", 64'(bus.resp_valid_o), 64'h1);
      chk("t4_hold_result", bus.resp_result_o, 64'hFFFF_FFFF_0000_0000);
      chk("t4_hold_tag", 64'(bus.resp_tag_o), 64'd3);
      chk("t4_hold_gnt", 64'(bus.gnt_o), 64'd0);
    end
    @(posedge clk); #1;
    bus.resp_ready_i = 2'b11;
    cyc("t4_accept", 2'b00, 1'b0, 2'b01);
    @(negedge clk);
    chk("t4_next_gnt", 64'(bus.gnt_o), 64'h2);
    chk("t4_next_busy", 64'(bus.busy_o), 64'd0);
    sb.push_back('{1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 5'd4});
    @(posedge clk); #1;
    bus.req_i = 2'b00;
    wait_idle("t4", 10);

    // T5: owner flushed while waiting on a slow multiplier
    lat = 3'd4;
    set_p0(32'd9, 32'd9, 1'b0, 5'd5);
    bus.req_i = 2'b01;
    cyc("t5_T0", 2'b01, 1'b0, 2'b00);
    bus.req_i = 2'b00;
    cyc("t5_T1", 2'b00, 1'b1, 2'b00);
    bus.flush_i = 2'b01;
    @(negedge clk);
    chk("t5_mul_flush", 64'(bus.mul_flush_o), 64'd1);
    chk("t5_no_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("t5_busy_wait", 64'(bus.busy_o), 64'd1);
    @(posedge clk); #1;
    bus.flush_i = 2'b00;
    lat = 3'd1;
    set_p0(32'd6, 32'd7, 1'b0, 5'd6);
    bus.req_i = 2'b01;
    @(negedge clk);
    chk("t5_idle_after_flush", 64'(bus.busy_o), 64'd0);
    chk("t5_regrant", 64'(bus.gnt_o), 64'h1);
    sb.push_back('{1'b0, 64'h0000_0000_0000_002A, 5'd6});
    @(posedge clk); #1;
    bus.req_i = 2'b00;
    wait_idle("t5", 10);

    // T6: reset during START; round-robin pointer returns to pipe 0
    set_p0(32'd1, 32'd1, 1'b0, 5'd9);
    bus.req_i = 2'b01;
    cyc("t6_T0", 2'b01, 1'b0, 2'b00);
    bus.req_i = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_mul_flush", 64'(bus.mul_flush_o), 64'd1);
    chk("t6_rst_start", 64'(bus.mul_start_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", 64'(bus.busy_o), 64'd0);
    chk("t6_start", 64'(bus.mul_start_o), 64'd0);
    chk("t6_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("t6_mul_a", 64'(bus.mul_a_o), 64'd0);
    chk("t6_mul_flush", 64'(bus.mul_flush_o), 64'd0);
    @(posedge clk); #1;
    set_p0(32'd4, 32'd4, 1'b0, 5'd10);
    set_p1(32'd8, 32'd8, 1'b0, 5'd11);
    bus.req_i = 2'b11;
    @(negedge clk);
    chk("t6_first_contention", 64'(bus.gnt_o), 64'h1);
    sb.push_back('{1'b0, 64'h0000_0000_0000_0010, 5'd10});
    @(posedge clk); #1;
    bus.req_i = 2'b00;
    wait_idle("t6", 10);

    repeat (5) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
